// File: rtl/seq_detect_param_if.sv
// Serial-line bundle for the pattern detector: sampling controls and bit in,
// match flag and counter out.
interface seq_detect_param_if #(
  parameter int PATTERN_W = 3,
  parameter int CNT_W     = 8
);
  logic                 en;
  logic                 in;
  logic [PATTERN_W-1:0] pattern;
  logic                 overlap;
  logic                 clear;
  logic                 out;
  logic [CNT_W-1:0]     match_count;
  logic                 count_sat;

  modport master (
    output en, in, pattern, overlap, clear,
    input  out, match_count, count_sat
  );

  modport slave (
    input  en, in, pattern, overlap, clear,
    output out, match_count, count_sat
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-programmable serial pattern detector with overlap control, input
// enable, synchronous clear and a saturating match counter.
module seq_detect_param #(
  parameter int PATTERN_W = 3,
  parameter int CNT_W     = 8
) (
  input  logic              clock,
  input  logic              reset,
  seq_detect_param_if.slave bus
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

  typedef enum logic {FILLING, ARMED} phase_t;

  logic [PATTERN_W-1:0] hist;
  logic [PATTERN_W-1:0] hist_nxt;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_nxt;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_nxt;
  logic                 out_q;
  logic                 sat_q;
  logic                 hit;
  phase_t               phase;
  phase_t               phase_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // A match needs a full window of accepted bits that equals the pattern
  // after the incoming bit has been shifted in.
  always_comb begin
    hist_nxt  = {hist[PATTERN_W-2:0], bus.in};
    phase     = (fill == FILL_FULL) ? ARMED : FILLING;
    fill_nxt  = (phase == ARMED) ? fill : fill + FILL_W'(1);
    phase_nxt = (fill_nxt == FILL_FULL) ? ARMED : FILLING;
    hit       = bus.en && (phase_nxt == ARMED) && (hist_nxt == bus.pattern);
    count_nxt = hit ? sat_inc(count) : count;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hist  <= '0;
      fill  <= '0;
      count <= '0;
      out_q <= 1'b0;
      sat_q <= 1'b0;
    end else if (bus.clear) begin
      hist  <= '0;
      fill  <= '0;
      count <= '0;
      out_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      out_q <= hit;
      if (bus.en) begin
        hist  <= hist_nxt;
        // Non-overlapping mode restarts the window so the next match
        // needs PATTERN_W fresh bits.
        fill  <= (hit && !bus.overlap) ? '0 : fill_nxt;
        count <= count_nxt;
        sat_q <= &count_nxt;
      end
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = count;
  assign bus.count_sat   = sat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed vector table plus randomized traffic
// on three parameterisations sharing one serial line.
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s_en, s_in, s_ovl, s_clr;
  logic [2:0] pa, pc;
  logic [3:0] pb;

  seq_detect_param_if #(.PATTERN_W(3), .CNT_W(8)) ia ();
  seq_detect_param_if #(.PATTERN_W(4), .CNT_W(8)) ib ();
  seq_detect_param_if #(.PATTERN_W(3), .CNT_W(2)) ic ();

  assign ia.en = s_en;  assign ia.in = s_in;  assign ia.overlap = s_ovl;
  assign ia.clear = s_clr;  assign ia.pattern = pa;
  assign ib.en = s_en;  assign ib.in = s_in;  assign ib.overlap = s_ovl;
  assign ib.clear = s_clr;  assign ib.pattern = pb;
  assign ic.en = s_en;  assign ic.in = s_in;  assign ic.overlap = s_ovl;
  assign ic.clear = s_clr;  assign ic.pattern = pc;

  seq_detect_param #(.PATTERN_W(3), .CNT_W(8)) u0 (.clock(clk), .reset(rst_n), .bus(ia.slave));
  seq_detect_param #(.PATTERN_W(4), .CNT_W(8)) u1 (.clock(clk), .reset(rst_n), .bus(ib.slave));
  seq_detect_param #(.PATTERN_W(3), .CNT_W(2)) u2 (.clock(clk), .reset(rst_n), .bus(ic.slave));

  int tests = 0;
  int fails = 0;

  // Reference model: count of fresh accepted bits plus the raw bit history.
  int     pw[3]   = '{3, 4, 3};
  int     cmax[3] = '{255, 255, 3};
  longint h[3];
  int     fresh[3];
  int     cnt[3];
  bit     eo[3];

  typedef struct {
    int d; bit r; bit c; bit e; bit b; bit o; int p; bit eo; int ec; bit es;
  } vec_t;
  vec_t vt[$];

  function automatic int patv(int k);
    case (k)
      0: return int'(pa);
      1: return int'(pb);
      default: return int'(pc);
    endcase
  endfunction

  function automatic int dut_out(int k);
    case (k)
      0: return int'(ia.out);
      1: return int'(ib.out);
      default: return int'(ic.out);
    endcase
  endfunction

  function automatic int dut_cnt(int k);
    case (k)
      0: return int'(ia.match_count);
      1: return int'(ib.match_count);
      default: return int'(ic.match_count);
    endcase
  endfunction

  function automatic int dut_sat(int k);
    case (k)
      0: return int'(ia.count_sat);
      1: return int'(ib.count_sat);
      default: return int'(ic.count_sat);
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step(input int k, input bit r, input bit c, input bit e, input bit b);
    longint mask;
    mask  = (64'd1 << pw[k]) - 64'd1;
    eo[k] = 1'b0;
    if (!r || c) begin
      h[k] = 0; fresh[k] = 0; cnt[k] = 0;
    end else if (e) begin
      h[k] = ((h[k] << 1) | longint'(b)) & mask;
      fresh[k]++;
      if (fresh[k] >= pw[k] && h[k] == longint'(patv(k))) begin
        eo[k] = 1'b1;
        if (cnt[k] < cmax[k]) cnt[k]++;
        if (!s_ovl) fresh[k] = 0;
      end
    end
  endtask

  task automatic tick(input bit r, input bit c, input bit e, input bit b);
    rst_n = r; s_clr = c; s_en = e; s_in = b;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k, r, c, e, b);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d out", tag, k), dut_out(k), int'(eo[k]));
      chk($sformatf("%s dut%0d count", tag, k), dut_cnt(k), cnt[k]);
      chk($sformatf("%s dut%0d count_sat", tag, k), dut_sat(k), int'(cnt[k] == cmax[k]));
    end
  endtask

  task automatic add(input int d, input bit r, input bit c, input bit e, input bit b,
                     input bit o, input int p, input bit x_o, input int x_c, input bit x_s);
    vec_t v;
    v = '{d, r, c, e, b, o, p, x_o, x_c, x_s};
    vt.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; s_en = 1'b0; s_in = 1'b0; s_ovl = 1'b1; s_clr = 1'b0;
    pa = 3'b111; pb = 4'b1011; pc = 3'b111;

    // d  r  c  e  b  o  pat  out cnt sat
    // 111, overlap: 1,1,1,0,0
    add(0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 1, 0);
    add(0, 1, 0, 1, 0, 1, 7, 0, 1, 0);
    add(0, 1, 0, 1, 0, 1, 7, 0, 1, 0);
    // six ones, overlap
    add(0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 1, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 2, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 3, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 4, 0);
    // six ones, non-overlap
    add(0, 0, 0, 0, 0, 0, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 7, 1, 1, 0);
    add(0, 1, 0, 1, 1, 0, 7, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0, 7, 0, 1, 0);
    add(0, 1, 0, 1, 1, 0, 7, 1, 2, 0);
    // width 4, 1011, overlap: 1,0,1,1,0,1,1
    add(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 11, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1, 11, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 11, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 11, 1, 1, 0);
    add(1, 1, 0, 1, 0, 1, 11, 0, 1, 0);
    add(1, 1, 0, 1, 1, 1, 11, 0, 1, 0);
    add(1, 1, 0, 1, 1, 1, 11, 1, 2, 0);
    // width 4, 1011, non-overlap
    add(1, 0, 0, 0, 0, 0, 11, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 11, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 11, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 11, 0, 0, 0);
    add(1, 1, 0, 1, 1, 0, 11, 1, 1, 0);
    add(1, 1, 0, 1, 0, 0, 11, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 11, 0, 1, 0);
    add(1, 1, 0, 1, 1, 0, 11, 0, 1, 0);
    // enable gap does not break the run
    add(0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 1, 0);
    // 2-bit counter saturation, then clear discards its bit
    add(2, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(2, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(2, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(2, 1, 0, 1, 1, 1, 7, 1, 1, 0);
    add(2, 1, 0, 1, 1, 1, 7, 1, 2, 0);
    add(2, 1, 0, 1, 1, 1, 7, 1, 3, 1);
    add(2, 1, 0, 1, 1, 1, 7, 1, 3, 1);
    add(2, 1, 0, 1, 1, 1, 7, 1, 3, 1);
    add(2, 1, 1, 1, 1, 1, 7, 0, 0, 0);
    add(2, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(2, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(2, 1, 0, 1, 1, 1, 7, 1, 1, 0);
    // reset mid-sequence loses partial progress
    add(0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 0, 0, 0);
    add(0, 1, 0, 1, 1, 1, 7, 1, 1, 0);

    @(negedge clk);
    foreach (vt[i]) begin
      case (vt[i].d)
        0: pa = 3'(vt[i].p);
        1: pb = 4'(vt[i].p);
        default: pc = 3'(vt[i].p);
      endcase
      s_ovl = vt[i].o;
      tick(vt[i].r, vt[i].c, vt[i].e, vt[i].b);
      chk($sformatf("vec%0d out", i), dut_out(vt[i].d), int'(vt[i].eo));
      chk($sformatf("vec%0d count", i), dut_cnt(vt[i].d), vt[i].ec);
      chk($sformatf("vec%0d count_sat", i), dut_sat(vt[i].d), int'(vt[i].es));
      check_model($sformatf("vec%0d", i));
    end

    // Random traffic, including live pattern/overlap changes.
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) s_ovl = ~s_ovl;
      if ($urandom_range(0, 99) == 0) begin
        pa = 3'($urandom); pb = 4'($urandom); pc = 3'($urandom);
      end
      tick($urandom_range(0, 199) != 0, $urandom_range(0, 99) == 0,
           $urandom_range(0, 3) != 0, 1'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
